// File: rtl/ps2_device.sv
// Device end of a PS/2 link: generates the clock, sends FIFO bytes to the host, receives and acks host commands.
// Optional macro PS2DEV_RESEND_EN: 0xFE from the host is consumed and the last sent byte is retransmitted.
module ps2_device #(
   parameter int HALF_BIT  = 2000,
   parameter int IDLE_HOLD = 2500,
   parameter int FIFO_AW   = 3
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire        ps2dclk,
   inout  wire        ps2ddat,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_perr,
   output logic       busy
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TMAX  = (HALF_BIT > IDLE_HOLD) ? HALF_BIT : IDLE_HOLD;
   localparam int TW    = $clog2(TMAX + 1);
   localparam logic [TW-1:0] HALF_END   = TW'(HALF_BIT - 1);
   localparam logic [TW-1:0] HOLD_END   = TW'(IDLE_HOLD - 1);
   // Lets the data synchronizer drain our own ack before a low data line counts as request-to-send.
   localparam logic [TW-1:0] RTS_SETTLE = TW'(4);

   typedef enum logic [2:0] {
      S_IDLE, S_TX_SETUP, S_TX_LOW, S_TX_HIGH, S_RX_LOW, S_RX_HIGH, S_ACK_LOW, S_ACK_HIGH
   } state_t;

   logic [1:0] clk_sync_reg, dat_sync_reg;
   logic       clk_s, dat_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_reg <= 2'b11;
         dat_sync_reg <= 2'b11;
      end else begin
         clk_sync_reg <= {clk_sync_reg[0], ps2dclk};
         dat_sync_reg <= {dat_sync_reg[0], ps2ddat};
      end
   end
   assign clk_s = clk_sync_reg[1];
   assign dat_s = dat_sync_reg[1];

   logic [7:0]         fifo_mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg;
   logic [7:0]         head_reg;
   logic               push, pop;

   assign tx_ready = (count_reg != (FIFO_AW+1)'(DEPTH));
   assign push     = tx_valid & tx_ready;

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= tx_data;
      head_reg <= fifo_mem[rd_ptr_reg];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (FIFO_AW+1)'(1);
            2'b01:   count_reg <= count_reg - (FIFO_AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   state_t     state_reg, state_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic [3:0] bit_reg, bit_next;
   logic [9:0] frame_reg, frame_next;
   logic [8:0] rx_shift_reg, rx_shift_next;
   logic       framing_reg, framing_next;
   logic       clk_rel_reg, clk_rel_next;
   logic       dat_rel_reg, dat_rel_next;
   logic [7:0] rx_data_reg, rx_data_next;
   logic       rx_valid_reg, rx_valid_next;
   logic       rx_perr_reg, rx_perr_next;
   logic       half_done, tx_done;
   logic       tx_pending, rx_consume;
   logic [7:0] tx_byte;

   assign half_done = (timer_reg == HALF_END);

`ifdef PS2DEV_RESEND_EN
   logic       resend_pending_reg, tx_resend_reg;
   logic [7:0] last_sent_reg, cur_byte_reg;

   assign rx_consume = (state_reg == S_ACK_HIGH) && (rx_shift_reg[7:0] == 8'hFE) &&
                       (^rx_shift_reg) && !framing_reg;
   assign tx_byte    = resend_pending_reg ? last_sent_reg : head_reg;
   assign tx_pending = (count_reg != '0) | resend_pending_reg;
   assign pop        = tx_done & ~tx_resend_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         resend_pending_reg <= 1'b0;
         tx_resend_reg      <= 1'b0;
         last_sent_reg      <= 8'hFA;
         cur_byte_reg       <= 8'h00;
      end else begin
         if (state_reg == S_IDLE && state_next == S_TX_SETUP) begin
            tx_resend_reg <= resend_pending_reg;
            cur_byte_reg  <= tx_byte;
         end
         if (tx_done) begin
            last_sent_reg <= cur_byte_reg;
            if (tx_resend_reg)
               resend_pending_reg <= 1'b0;
         end
         if (half_done && rx_consume)
            resend_pending_reg <= 1'b1;
      end
   end
`else
   assign rx_consume = 1'b0;
   assign tx_byte    = head_reg;
   assign tx_pending = (count_reg != '0);
   assign pop        = tx_done;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         timer_reg    <= '0;
         bit_reg      <= '0;
         frame_reg    <= '1;
         rx_shift_reg <= '0;
         framing_reg  <= 1'b0;
         clk_rel_reg  <= 1'b1;
         dat_rel_reg  <= 1'b1;
         rx_data_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
         rx_perr_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         bit_reg      <= bit_next;
         frame_reg    <= frame_next;
         rx_shift_reg <= rx_shift_next;
         framing_reg  <= framing_next;
         clk_rel_reg  <= clk_rel_next;
         dat_rel_reg  <= dat_rel_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         rx_perr_reg  <= rx_perr_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      timer_next    = timer_reg + TW'(1);
      bit_next      = bit_reg;
      frame_next    = frame_reg;
      rx_shift_next = rx_shift_reg;
      framing_next  = framing_reg;
      clk_rel_next  = clk_rel_reg;
      dat_rel_next  = dat_rel_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      rx_perr_next  = rx_perr_reg;
      tx_done       = 1'b0;
      unique case (state_reg)
         S_IDLE: begin
            clk_rel_next = 1'b1;
            dat_rel_next = 1'b1;
            if (!clk_s) begin
               timer_next = '0;
            end else if (!dat_s && timer_reg >= RTS_SETTLE) begin
               state_next   = S_RX_LOW;
               timer_next   = '0;
               clk_rel_next = 1'b0;
               bit_next     = '0;
               framing_next = 1'b0;
            end else if (timer_reg == HOLD_END) begin
               timer_next = timer_reg;
               if (tx_pending) begin
                  state_next   = S_TX_SETUP;
                  timer_next   = '0;
                  frame_next   = {1'b1, ~^tx_byte, tx_byte};
                  dat_rel_next = 1'b0;
                  bit_next     = '0;
               end
            end
         end
         S_TX_SETUP: if (half_done) begin
            state_next   = S_TX_LOW;
            timer_next   = '0;
            clk_rel_next = 1'b0;
         end
         S_TX_LOW: if (half_done) begin
            state_next   = S_TX_HIGH;
            timer_next   = '0;
            clk_rel_next = 1'b1;
         end
         S_TX_HIGH: if (half_done) begin
            timer_next = '0;
            if (bit_reg == 4'd10) begin
               state_next   = S_IDLE;
               dat_rel_next = 1'b1;
               tx_done      = 1'b1;
            end else if (!clk_s) begin
               // Host inhibit mid-frame: give up; the byte stays queued.
               state_next   = S_IDLE;
               clk_rel_next = 1'b1;
               dat_rel_next = 1'b1;
            end else begin
               state_next   = S_TX_SETUP;
               bit_next     = bit_reg + 4'd1;
               dat_rel_next = frame_reg[0];
               frame_next   = {1'b1, frame_reg[9:1]};
            end
         end
         S_RX_LOW: if (half_done) begin
            state_next   = S_RX_HIGH;
            timer_next   = '0;
            clk_rel_next = 1'b1;
         end
         S_RX_HIGH: if (half_done) begin
            timer_next   = '0;
            clk_rel_next = 1'b0;
            if (bit_reg != 4'd9) begin
               rx_shift_next = {dat_s, rx_shift_reg[8:1]};
               bit_next      = bit_reg + 4'd1;
               state_next    = S_RX_LOW;
            end else if (dat_s) begin
               state_next   = S_ACK_LOW;
               dat_rel_next = 1'b0;
            end else begin
               // Stop bit low: keep clocking until the host releases data.
               framing_next = 1'b1;
               state_next   = S_RX_LOW;
            end
         end
         S_ACK_LOW: if (half_done) begin
            state_next   = S_ACK_HIGH;
            timer_next   = '0;
            clk_rel_next = 1'b1;
         end
         S_ACK_HIGH: if (half_done) begin
            state_next   = S_IDLE;
            timer_next   = '0;
            dat_rel_next = 1'b1;
            if (!rx_consume) begin
               rx_valid_next = 1'b1;
               rx_data_next  = rx_shift_reg[7:0];
               rx_perr_next  = ~(^rx_shift_reg) | framing_reg;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign ps2dclk  = clk_rel_reg ? 1'bz : 1'b0;
   assign ps2ddat  = dat_rel_reg ? 1'bz : 1'b0;
   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;
   assign rx_perr  = rx_perr_reg;
   assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: a host model drives and observes the open-collector lines; scoreboards hold expected bytes.
module tb_ps2_device;

   localparam int HALF = 8;
   localparam int HOLD = 20;
   localparam int AW   = 3;

   logic       clk;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_perr;
   logic       busy;
   wire        ps2dclk;
   wire        ps2ddat;
   logic       host_clk_low, host_dat_low, host_sending;

   pullup (ps2dclk);
   pullup (ps2ddat);
   assign ps2dclk = host_clk_low ? 1'b0 : 1'bz;
   assign ps2ddat = host_dat_low ? 1'b0 : 1'bz;

   ps2_device #(.HALF_BIT(HALF), .IDLE_HOLD(HOLD), .FIFO_AW(AW)) dut (
      .clk(clk), .reset(reset), .ps2dclk(ps2dclk), .ps2ddat(ps2ddat),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_perr(rx_perr), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int frames_done = 0;
   int mon_nbits = 0;
   logic [7:0] tx_exp[$];
   logic [8:0] rx_exp[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Device-to-host frame monitor: bits taken at each falling clock edge.
   logic [10:0] mon_bits;
   logic        mon_prev = 1'b1;
   int          mon_low = 0, mon_bad = 0;
   logic [7:0]  mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (host_clk_low || host_sending || reset) begin
            mon_nbits = 0; mon_low = 0; mon_bad = 0;
         end else if (mon_prev && !ps2dclk) begin
            if (mon_nbits < 11) mon_bits[mon_nbits] = ps2ddat;
            mon_nbits++;
            mon_low = 1;
         end else if (!ps2dclk) begin
            mon_low++;
         end else if (!mon_prev && mon_nbits > 0) begin
            if (mon_low != HALF) mon_bad++;
            if (mon_nbits == 11) begin
               $display("tx frame %03h", mon_bits);
               if (tx_exp.size() == 0) check("tx_extra", 1, 0);
               else begin
                  mon_e = tx_exp.pop_front();
                  check("tx_frame", {21'd0, mon_bits}, {21'd0, 1'b1, ~^mon_e, mon_e, 1'b0});
                  check("tx_lowlen", mon_bad, 0);
               end
               frames_done++;
               mon_nbits = 0; mon_bad = 0;
            end
         end
         mon_prev = ps2dclk;
      end
   end

   logic [8:0] rx_e;
   initial begin
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            $display("rx byte %02h perr %b", rx_data, rx_perr);
            if (rx_exp.size() == 0) check("rx_extra", 1, 0);
            else begin
               rx_e = rx_exp.pop_front();
               check("rx_data", rx_data, rx_e[7:0]);
               check("rx_perr", rx_perr, rx_e[8]);
            end
            @(negedge clk);
            check("rx_pulse", rx_valid, 0);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic push_byte(input logic [7:0] b, output logic acc);
      @(negedge clk);
      tx_data = b; tx_valid = 1'b1;
      acc = tx_ready;
      if (acc) tx_exp.push_back(b);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      for (int k = 0; k < 5000 && frames_done < target; k++) @(negedge clk);
      if (frames_done < target) check("frame_timeout", frames_done, target);
   endtask

   task automatic wait_nbits(input int n);
      for (int k = 0; k < 2000 && mon_nbits < n; k++) @(negedge clk);
      if (mon_nbits < n) check("bit_timeout", mon_nbits, n);
   endtask

   task automatic wait_fall();
      logic prev, ok;
      prev = ps2dclk; ok = 1'b0;
      for (int k = 0; k < 4*HALF + 16; k++) begin
         @(negedge clk);
         if (prev && !ps2dclk) begin ok = 1'b1; break; end
         prev = ps2dclk;
      end
      if (!ok) check("fall_timeout", 0, 1);
   endtask

   task automatic send_cmd(input logic [7:0] b, input logic par_ok, input logic stop_one, input logic expect_rx);
      logic [9:0] bits;
      int low_n;
      bits = {stop_one, (par_ok ? ~^b : ^b), b};
      if (expect_rx) rx_exp.push_back({(!par_ok || !stop_one), b});
      host_sending = 1'b1; host_clk_low = 1'b1;
      repeat (4*HALF) @(negedge clk);
      host_dat_low = 1'b1;
      repeat (4) @(negedge clk);
      host_clk_low = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wait_fall();
         host_dat_low = !bits[i];
      end
      if (!stop_one) begin
         wait_fall();
         host_dat_low = 1'b0;
      end
      wait_fall();
      check("ack_low", ps2ddat, 0);
      low_n = 0;
      for (int k = 0; k < 8*HALF && ps2ddat == 1'b0; k++) begin
         low_n++;
         @(negedge clk);
      end
      check("ack_len", low_n, 2*HALF);
      host_sending = 1'b0;
   endtask

   logic acc;
   int   base;
   initial begin
      reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
      host_clk_low = 1'b0; host_dat_low = 1'b0; host_sending = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_perr", rx_perr, 0);
      check("rst_lines", {ps2dclk, ps2ddat}, 2'b11);
      reset = 1'b0;

      // Single byte, idle host.
      push_byte(8'hF4, acc);
      check("push_f4", acc, 1);
      check("ready_f4", tx_ready, 1);
      wait_frames(1);
      repeat (2*HALF) @(negedge clk);
      check("busy_drop", busy, 0);

      // Fill the FIFO under inhibit; the ninth push is refused.
      host_clk_low = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         push_byte(8'h10 + 8'(i * 7), acc);
         if (i == 8) check("push9_ignored", acc, 0);
      end
      check("full_ready", tx_ready, 0);
      check("inhibit_busy", busy, 0);
      base = frames_done;
      host_clk_low = 1'b0;
      wait_frames(base + 8);
      check("ready_after", tx_ready, 1);

      // Inhibit during bit 5 of 0xAA, then one full resend.
      push_byte(8'hAA, acc);
      base = frames_done;
      wait_nbits(6);
      repeat (HALF/2) @(negedge clk);
      host_clk_low = 1'b1;
      repeat (3*HALF) @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_dat", ps2ddat, 1);
      host_clk_low = 1'b0;
      wait_frames(base + 1);
      repeat (400) @(negedge clk);
      check("resend_once", frames_done, base + 1);

      // Host commands: good parity, bad parity, low stop bit.
      send_cmd(8'hFF, 1'b1, 1'b1, 1'b1);
      send_cmd(8'hFF, 1'b0, 1'b1, 1'b1);
      send_cmd(8'h55, 1'b1, 1'b0, 1'b1);

      // RTS has priority over a queued byte.
      host_clk_low = 1'b1;
      push_byte(8'hFA, acc);
      base = frames_done;
      send_cmd(8'hF3, 1'b1, 1'b1, 1'b1);
      check("rx_first", frames_done, base);
      wait_frames(base + 1);

`ifdef PS2DEV_RESEND_EN
      push_byte(8'h08, acc);
      base = frames_done;
      wait_frames(base + 1);
      tx_exp.push_back(8'h08);
      send_cmd(8'hFE, 1'b1, 1'b1, 1'b0);
      wait_frames(base + 2);
`else
      send_cmd(8'hFE, 1'b1, 1'b1, 1'b1);
`endif
      repeat (4) @(negedge clk);

      // Reset mid-frame: lines released next cycle, frame discarded.
      push_byte(8'h3C, acc);
      base = frames_done;
      wait_nbits(3);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_clk", ps2dclk, 1);
      check("midrst_busy", busy, 0);
      check("midrst_ready", tx_ready, 1);
      tx_exp.delete();
      reset = 1'b0;
      repeat (500) @(negedge clk);
      check("midrst_nosend", frames_done, base);

      check("tx_queue_empty", tx_exp.size(), 0);
      check("rx_queue_empty", rx_exp.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_device.md
Name: ps2_device

Overview:
Device-side end of the PS/2 link: the counterpart to the host mouse controller, for emulating a mouse or keyboard toward an external host or for loopback test of the host block. It generates the PS/2 clock, sends queued bytes device-to-host, and detects host request-to-send. It also receives host command bytes with parity check and acknowledges each one. Open-collector lines match the host block: a line is released (z) when driven 1 and pulled to 0 otherwise.

Parameters:
HALF_BIT, 2000, clk cycles per PS/2 clock half-period (12.5 kHz at 50 MHz)
IDLE_HOLD, 2500, clk cycles the clock line must be seen high before a transmission starts
FIFO_AW, 3, TX FIFO address width (depth 2**FIFO_AW)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
ps2dclk  inout  1  PS/2 clock, open collector, driven low or z
ps2ddat  inout  1  PS/2 data, open collector, driven low or z
tx_data  input  8  byte to send to host
tx_valid  input  1  push request
tx_ready  output  1  FIFO not full
rx_data  output  8  last host command byte
rx_valid  output  1  one-cycle pulse, new rx_data
rx_perr  output  1  parity error on the byte flagged by rx_valid
busy  output  1  state is not IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- ps2dclk and ps2ddat are sampled through 2-FF synchronizers. "Line high/low" below means the synchronized value.
- Reset: both lines released; FIFO emptied; tx_ready=1; rx_data=0; rx_valid=0; rx_perr=0; busy=0; state IDLE.
- Reset asserted mid-frame releases both lines on the next clk and discards the partial frame. A byte popped by completion is never resent.
- FIFO: a push occurs when tx_valid & tx_ready. A pop occurs only after a frame completes successfully. Simultaneous push and pop are both honoured; count is unchanged. A push while full is ignored.
- One shared timer counts half-periods and the idle hold.
- State IDLE:
  - Clock low: host inhibit. Reset the hold timer and stay.
  - Clock high and data low: host request-to-send. Go to RX. RX has priority over pending TX.
  - Clock high for IDLE_HOLD consecutive cycles and FIFO not empty: go to TX.
- State TX: 11-bit frame. Start 0, data[0..7] LSB first, odd parity, stop 1.
  - Per bit: drive data, wait HALF_BIT, pull clock low for HALF_BIT, release clock for HALF_BIT.
  - At the end of each released-high half, if clock is low (host inhibit) and the bit is before the stop bit: abort, release both lines, return to IDLE. The byte stays in the FIFO.
  - After the stop bit's high half: pop, go to IDLE.
- State RX (host-to-device):
  - Device generates 11 clocks at the same half-period.
  - Data is sampled at the end of each high half. Sequence: 8 data bits LSB first, parity, then stop.
  - If stop is 1: drive data low for the next full clock period (ack), then release.
  - If stop is 0: keep clocking until data is seen high, then send ack, and force rx_perr=1.
  - After the ack: rx_data updates, rx_valid pulses 1 cycle, rx_perr = (parity not odd) | framing error. Go to IDLE.
- rx_valid and the FIFO pop never occur in the same cycle as reset.

Optional Feature:
PS2DEV_RESEND_EN:
- Defined: a received command 0xFE with good parity is consumed internally. No rx_valid pulse. The last successfully sent byte is held in a register and retransmitted ahead of the FIFO head. If nothing has been sent since reset, 0xFA is sent instead.
- Undefined: 0xFE is delivered on rx_data like any other byte; no shadow register exists.

Test Plan:
- Push 0xF4, host model idle -> clock has 11 low pulses of HALF_BIT; frame data 0,0,0,1,0,1,1,1,1,0,1; tx_ready stays 1; busy then drops.
- Push 9 bytes with depth 8 and host held inhibited -> 9th push ignored, tx_ready=0. After release, the 8 bytes are sent in order.
- Host pulls clock low during bit 5 of 0xAA -> abort, lines released; after release and IDLE_HOLD, 0xAA is resent in full exactly once.
- Host RTS sending 0xFF with parity 1 -> device ack low one period; rx_valid pulse, rx_data=0xFF, rx_perr=0. Repeat with parity 0 -> rx_perr=1.
- Host RTS with 0xF3 while FIFO holds 0xFA -> RX completes first (rx_data=0xF3), then 0xFA is transmitted.
- With PS2DEV_RESEND_EN, send 0x08, then host sends 0xFE -> no rx_valid; 0x08 is retransmitted. Without the macro -> rx_valid with rx_data=0xFE.
